axi_sram_rd_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_sram_rd_slave.sv | 121 ++++++++++++
 tb/tb_axi_sram_rd_slave.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, response/burst codes and the read-responder state type.
package axi_pkg;

  localparam int AXI_ID_W    = 8;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_SRAM_AW = 14;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only full 32-bit beats are supported by the SRAM datapath.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } rd_state_e;

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

endpackage

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read responder: serves one AR burst at a time from a synchronous
// single-port SRAM, alternating FETCH (address the macro) and SEND (present R beat).
module axi_sram_rd_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = AXI_ID_W,
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int DATA_W  = AXI_DATA_W,
  parameter int SRAM_AW = AXI_SRAM_AW
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [ID_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [DATA_W-1:0]  RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               SRAM_CS,
  output logic               SRAM_OE,
  output logic [SRAM_AW-1:0] SRAM_A,
  input  logic [DATA_W-1:0]  SRAM_DO
);

  rd_state_e          state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         burst_q, burst_d;
  logic               err_q, err_d;

  // Byte-lane bits and bits above the SRAM window are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

  logic send;
  logic last_beat;
  assign send      = (state_q == SEND);
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR[SRAM_AW+1:2];
          len_d   = ARLEN;
          burst_d = ARBURST;
          err_d   = burst_err(ARSIZE, ARBURST);
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        if (RREADY) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            // Error bursts replay the same word; only clean INCR bursts advance.
            if ((burst_q == BURST_INCR) && !err_q) addr_d = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= BURST_FIXED;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign ARREADY = (state_q == IDLE);

  // SRAM stays addressed through SEND so DO is stable while RREADY stalls.
  assign SRAM_CS = (state_q != IDLE);
  assign SRAM_OE = (state_q != IDLE);
  assign SRAM_A  = addr_q;

  assign RVALID = send;
  assign RDATA  = send ? SRAM_DO : '0;
  assign RID    = id_q;
  assign RRESP  = (send && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST  = send && last_beat;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed bench for axi_sram_rd_slave with a behavioural SRAM whose contents
// are a fixed function of the word address.
module tb_axi_sram_rd_slave;

  logic        clk;
  logic        rst_n;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        sram_cs;
  logic        sram_oe;
  logic [13:0] sram_a;
  logic [31:0] sram_do;

  int errors = 0;
  int checks = 0;

  axi_sram_rd_slave dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .ARID    (arid),
    .ARADDR  (araddr),
    .ARLEN   (arlen),
    .ARSIZE  (arsize),
    .ARBURST (arburst),
    .ARVALID (arvalid),
    .ARREADY (arready),
    .RID     (rid),
    .RDATA   (rdata),
    .RRESP   (rresp),
    .RLAST   (rlast),
    .RVALID  (rvalid),
    .RREADY  (rready),
    .SRAM_CS (sram_cs),
    .SRAM_OE (sram_oe),
    .SRAM_A  (sram_a),
    .SRAM_DO (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [13:0] a);
    return ({18'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous SRAM: DO reflects the address sampled on the previous edge.
  always @(posedge clk) begin
    if (sram_cs && sram_oe) sram_do <= mem_val(sram_a);
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [13:0] a0;    // hand-computed first word address
    bit          inc;   // address advances between beats
    logic [1:0]  resp;  // expected RRESP on every beat
  } vec_t;

  vec_t vecs[5];

  task automatic run_burst(input vec_t v);
    logic [13:0] a;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len;
    arsize = v.size; arburst = v.burst;
    @(negedge clk);
    check("arready_idle", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0; arid = 8'hEE; araddr = 32'hDEAD_BEEF; arlen = 4'hF;
    arsize = 3'b111; arburst = 2'b11;
    a = v.a0;
    for (int i = 0; i <= int'(v.len); i++) begin
      @(negedge clk);
      check("fetch_a", sram_a, a);
      check("fetch_cs", {sram_cs, sram_oe, rvalid}, 3'b110);
      @(negedge clk);
      check("send_rvalid", rvalid, 1'b1);
      check("send_rdata", rdata, mem_val(a));
      check("send_rid", rid, v.id);
      check("send_rresp", rresp, v.resp);
      check("send_rlast", rlast, (i == int'(v.len)));
      check("send_arready", arready, 1'b0);
      if (v.inc) a = a + 14'd1;
    end
    @(negedge clk);
    check("post_arready", arready, 1'b1);
    check("post_rvalid", rvalid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{id: 8'h15, addr: 32'h0000_0010, len: 4'd0, size: 3'b010, burst: 2'b01,
                a0: 14'h0004, inc: 1'b1, resp: 2'b00};
    vecs[1] = '{id: 8'h2A, addr: 32'h0000_FFF8, len: 4'd3, size: 3'b010, burst: 2'b01,
                a0: 14'h3FFE, inc: 1'b1, resp: 2'b00};
    vecs[2] = '{id: 8'h33, addr: 32'h0000_0204, len: 4'd2, size: 3'b010, burst: 2'b00,
                a0: 14'h0081, inc: 1'b0, resp: 2'b00};
    vecs[3] = '{id: 8'h44, addr: 32'h0000_0100, len: 4'd1, size: 3'b001, burst: 2'b01,
                a0: 14'h0040, inc: 1'b0, resp: 2'b10};
    vecs[4] = '{id: 8'h55, addr: 32'hABCD_000B, len: 4'd1, size: 3'b010, burst: 2'b10,
                a0: 14'h0002, inc: 1'b0, resp: 2'b10};

    rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arsize = 3'b010; arburst = 2'b01; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_arready", arready, 1'b1);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_sram", {sram_cs, sram_oe, sram_a}, 16'h0);
    check("rst_r", {rid, rresp, rlast, rdata}, 43'h0);

    for (int v = 0; v < 5; v++) run_burst(vecs[v]);

    // Stall in SEND for 5 cycles; a competing ARVALID must be ignored.
    rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 8'h66; araddr = 32'h0000_0040; arlen = 4'd0;
    arsize = 3'b010; arburst = 2'b01;
    @(posedge clk); #1;
    arid = 8'h77; araddr = 32'h0000_0080;
    @(negedge clk);
    check("stall_fetch_a", sram_a, 14'h0010);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_rvalid", rvalid, 1'b1);
      check("stall_rdata", rdata, mem_val(14'h0010));
      check("stall_rid", rid, 8'h66);
      check("stall_rlast", rlast, 1'b1);
      check("stall_arready", arready, 1'b0);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge clk);
    check("stall_done_rvalid", rvalid, 1'b0);
    check("stall_done_arready", arready, 1'b1);

    // Reset asserted mid-burst: outputs drop immediately, no RLAST.
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 8'h99; araddr = 32'h0000_0000; arlen = 4'd3;
    arsize = 3'b010; arburst = 2'b01;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_arready", arready, 1'b1);
    check("mid_rst_out", {sram_cs, rlast, rid, rdata}, 42'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_burst(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
